fifo_fill_gen: RTL and testbench

- Upstream producer stage for the FIFO drained by the team's fifo_drain block.
- On an ap_start handshake, latches a job (burst size, burst count, seed, step) and writes size*times words of an arithmetic pattern into a FIFO write port, honouring fifo_full backpressure.
- Signals completion with the same ap_start/ap_idle/ap_ready/ap_done protocol as the rest of the test chain, so the drain side can check the sequence end to end.

---
 rtl/fifo_test_pkg.sv | 34 +++
 rtl/fifo_fill_gen.sv | 155 +++++++++++++++
 tb/tb_fifo_fill_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_test_pkg.sv
// ---------------------------------------------------------------------------
// fifo_test_pkg
// Shared definitions for the FIFO test chain (fifo_fill_gen on the producer
// side, fifo_drain on the consumer side).
//
// Contents:
//   state_t      - IDLE / RUN / DONE job state, explicitly encoded
//   ap_status_t  - bundle of the ap_idle / ap_ready / ap_done outputs
//   AP_*_STATUS  - the handshake output patterns used in each phase of a job
// ---------------------------------------------------------------------------
package fifo_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic idle;
    logic ready;
    logic done;
  } ap_status_t;

  // Waiting for work, nothing accepted this cycle.
  localparam ap_status_t AP_IDLE_STATUS   = '{idle: 1'b1, ready: 1'b0, done: 1'b0};
  // ap_start seen while idle: job latched on this edge.
  localparam ap_status_t AP_ACCEPT_STATUS = '{idle: 1'b0, ready: 1'b1, done: 1'b0};
  // Job in progress.
  localparam ap_status_t AP_BUSY_STATUS   = '{idle: 1'b0, ready: 1'b0, done: 1'b0};
  // Single completion cycle.
  localparam ap_status_t AP_DONE_STATUS   = '{idle: 1'b0, ready: 1'b0, done: 1'b1};

endpackage

// File: rtl/fifo_fill_gen.sv
// ---------------------------------------------------------------------------
// fifo_fill_gen
// Producer stage for the test FIFO. On an ap_start handshake it latches a job
// and writes size*times words of an arithmetic pattern (seed, seed+step, ...)
// into a FIFO write port, stalling while the FIFO reports full. The pattern
// runs straight across burst boundaries; bursts only matter for the counters.
//
// Ports:
//   ap_clk        clock, rising edge
//   ap_rst_n      asynchronous active-low reset
//   size, times   words per burst / number of bursts (latched at start)
//   seed, step    first word / increment, modulo 2^WIDTH (latched at start)
//   fifo_wr_en    write strobe, low whenever fifo_full is high
//   fifo_wr_data  registered write data
//   fifo_full     FIFO backpressure
//   ap_start      job request
//   ap_idle       no job active
//   ap_ready      one-cycle pulse: job accepted
//   ap_done       one-cycle pulse: job complete
//   wr_count      accepted writes since the last job start
// ---------------------------------------------------------------------------
module fifo_fill_gen
  import fifo_test_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic [31:0]      size,
  input  logic [31:0]      times,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] step,
  output logic             fifo_wr_en,
  output logic [WIDTH-1:0] fifo_wr_data,
  input  logic             fifo_full,
  input  logic             ap_start,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  output logic [31:0]      wr_count
);

  state_t           state;
  state_t           next_state;
  ap_status_t       ap_status;
  logic             start_accept;
  logic [31:0]      size_q;
  logic [31:0]      times_q;
  logic [WIDTH-1:0] step_q;
  logic [31:0]      size_cnt;
  logic [31:0]      times_cnt;
  logic             burst_last;
  logic             job_last;

  // Counters only reach these compares in RUN, where size_q and times_q are
  // both known to be non-zero, so the -1 never underflows in a way that matters.
  assign burst_last = (size_cnt == size_q - 32'd1);
  assign job_last   = (times_cnt == times_q - 32'd1);

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake and write-strobe outputs. ap_ready is masked by reset so that
  // a start held high during reset is not reported as accepted.
  always_comb begin
    ap_status    = AP_IDLE_STATUS;
    fifo_wr_en   = 1'b0;
    start_accept = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start && ap_rst_n) begin
          ap_status    = AP_ACCEPT_STATUS;
          start_accept = 1'b1;
        end
      end
      RUN: begin
        ap_status  = AP_BUSY_STATUS;
        fifo_wr_en = !fifo_full;
      end
      DONE: begin
        ap_status = AP_DONE_STATUS;
      end
      default: begin
        ap_status = AP_IDLE_STATUS;
      end
    endcase
  end

  assign ap_idle  = ap_status.idle;
  assign ap_ready = ap_status.ready;
  assign ap_done  = ap_status.done;

  // Next-state logic. An empty job (size or times zero) skips RUN entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_accept) begin
          next_state = ((size == 32'd0) || (times == 32'd0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fifo_wr_en && burst_last && job_last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Job registers, pattern generator and burst counters. Everything advances
  // only on an accepted write, so a full FIFO freezes the whole datapath.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      size_q       <= '0;
      times_q      <= '0;
      step_q       <= '0;
      fifo_wr_data <= '0;
      wr_count     <= '0;
      size_cnt     <= '0;
      times_cnt    <= '0;
    end else if (start_accept) begin
      size_q       <= size;
      times_q      <= times;
      step_q       <= step;
      fifo_wr_data <= seed;
      wr_count     <= '0;
      size_cnt     <= '0;
      times_cnt    <= '0;
    end else if (fifo_wr_en) begin
      fifo_wr_data <= fifo_wr_data + step_q;
      wr_count     <= wr_count + 32'd1;
      if (burst_last) begin
        size_cnt <= '0;
        if (!job_last) begin
          times_cnt <= times_cnt + 32'd1;
        end
      end else begin
        size_cnt <= size_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_fill_gen.sv
// ---------------------------------------------------------------------------
// tb_fifo_fill_gen
// Self-checking bench for fifo_fill_gen. Job vectors come from a table; the
// expected write stream of each job goes into a scoreboard queue when the job
// is started and is popped as the DUT strobes fifo_wr_en. Reset mid-job and
// back-to-back starts are covered by hand-written sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_fill_gen;

  localparam int WIDTH = 8;

  typedef struct {
    logic [31:0]      size;
    logic [31:0]      times;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] step;
    logic [31:0]      fullMask;
    int               expDone;
    int               expWrites;
  } vec_t;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic [31:0]      size;
  logic [31:0]      times;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] step;
  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_wr_data;
  logic             fifo_full;
  logic             ap_start;
  logic             ap_idle;
  logic             ap_ready;
  logic             ap_done;
  logic [31:0]      wr_count;

  int               checks = 0;
  int               failures = 0;
  logic [WIDTH-1:0] expQ[$];
  vec_t             vecs[8];

  fifo_fill_gen #(.WIDTH(WIDTH)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .size        (size),
    .times       (times),
    .seed        (seed),
    .step        (step),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_full   (fifo_full),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .wr_count    (wr_count)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare one observed write against the head of the scoreboard.
  task automatic checkWrite(input string name);
    checkOutput({name, "_sb_has_entry"}, 32'(expQ.size() != 0), 32'd1);
    if (expQ.size() != 0) begin
      checkOutput({name, "_data"}, 32'(fifo_wr_data), 32'(expQ.pop_front()));
    end
  endtask

  // Start one job from the table and follow it to completion. Called just
  // after a rising edge with the DUT idle.
  task automatic applyStimulus(input vec_t v);
    logic [WIDTH-1:0] d;
    int writes;
    int doneCyc;
    longint total;
    size     = v.size;
    times    = v.times;
    seed     = v.seed;
    step     = v.step;
    ap_start = 1'b1;
    fifo_full = v.fullMask[0];
    total = longint'(v.size) * longint'(v.times);
    d = v.seed;
    for (longint i = 0; i < total; i++) begin
      expQ.push_back(d);
      d = d + v.step;
    end
    @(negedge ap_clk);
    checkOutput("ready_at_start", 32'(ap_ready), 32'd1);
    checkOutput("idle_at_start", 32'(ap_idle), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    writes  = 0;
    doneCyc = -1;
    for (int c = 1; c <= 64 && doneCyc < 0; c++) begin
      fifo_full = (c < 32) ? v.fullMask[c] : 1'b0;
      @(negedge ap_clk);
      checkOutput("wr_en_blocked_by_full", 32'(fifo_wr_en & fifo_full), 32'd0);
      if (fifo_wr_en) begin
        writes++;
        checkWrite("job");
      end
      if (ap_done) doneCyc = c;
      @(posedge ap_clk);
      #1;
    end
    fifo_full = 1'b0;
    checkOutput("done_cycle", 32'(doneCyc), 32'(v.expDone));
    checkOutput("write_count", 32'(writes), 32'(v.expWrites));
    checkOutput("wr_count_final", wr_count, 32'(v.expWrites));
    checkOutput("idle_after_done", 32'(ap_idle), 32'd1);
    checkOutput("sb_empty_after_job", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    int doneSeen;
    int wrSeen;
    logic [11:0] readyBits;
    logic [11:0] doneBits;
    logic [11:0] wrBits;
    logic [WIDTH-1:0] d;

    // size, times, seed, step, fullMask, expDone, expWrites
    vecs[0] = '{32'd4, 32'd2, 8'h10, 8'h01, 32'h0000_0000, 9, 8};
    vecs[1] = '{32'd3, 32'd1, 8'hFE, 8'h01, 32'h0000_0000, 4, 3};
    vecs[2] = '{32'd5, 32'd1, 8'h00, 8'h02, 32'h0000_001C, 9, 5};
    vecs[3] = '{32'd0, 32'd7, 8'h33, 8'h01, 32'h0000_0000, 1, 0};
    vecs[4] = '{32'd7, 32'd0, 8'h33, 8'h01, 32'h0000_0000, 1, 0};
    vecs[5] = '{32'd1, 32'd3, 8'h80, 8'h81, 32'h0000_0000, 4, 3};
    vecs[6] = '{32'd2, 32'd2, 8'h03, 8'hFF, 32'h0000_0008, 6, 4};
    vecs[7] = '{32'd3, 32'd2, 8'hA0, 8'h10, 32'h0000_0006, 9, 6};

    ap_rst_n  = 1'b0;
    size      = '0;
    times     = '0;
    seed      = '0;
    step      = '0;
    fifo_full = 1'b0;
    ap_start  = 1'b1;

    // Reset state, with ap_start deliberately high to show it is not accepted.
    @(negedge ap_clk);
    checkOutput("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("reset_idle", 32'(ap_idle), 32'd1);
    checkOutput("reset_ready", 32'(ap_ready), 32'd0);
    checkOutput("reset_done", 32'(ap_done), 32'd0);
    checkOutput("reset_wr_data", 32'(fifo_wr_data), 32'd0);
    checkOutput("reset_wr_count", wr_count, 32'd0);
    ap_start = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d: size=%0d times=%0d seed=%0h step=%0h",
               i, vecs[i].size, vecs[i].times, vecs[i].seed, vecs[i].step);
      applyStimulus(vecs[i]);
    end

    // Reset in the middle of a job: abandoned with no ap_done.
    $display("[TB] reset mid-job");
    size = 32'd10; times = 32'd1; seed = 8'h20; step = 8'h01; ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start = 1'b0;
    repeat (3) @(posedge ap_clk);
    #2;
    checkOutput("pre_reset_wr_count", wr_count, 32'd3);
    checkOutput("pre_reset_wr_data", 32'(fifo_wr_data), 32'h23);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("async_reset_wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("async_reset_idle", 32'(ap_idle), 32'd1);
    checkOutput("async_reset_done", 32'(ap_done), 32'd0);
    checkOutput("async_reset_wr_count", wr_count, 32'd0);
    checkOutput("async_reset_wr_data", 32'(fifo_wr_data), 32'd0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    doneSeen = 0;
    wrSeen   = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge ap_clk);
      if (ap_done) doneSeen++;
      if (fifo_wr_en) wrSeen++;
    end
    checkOutput("no_done_after_reset", 32'(doneSeen), 32'd0);
    checkOutput("no_write_after_reset", 32'(wrSeen), 32'd0);
    @(posedge ap_clk);
    #1;
    applyStimulus('{32'd2, 32'd1, 8'h05, 8'h01, 32'h0000_0000, 3, 2});

    // ap_start held high: jobs run back to back and start is ignored in
    // RUN and DONE. Three jobs are accepted at cycles 0, 4 and 8.
    $display("[TB] back-to-back starts");
    readyBits = 12'h111;
    doneBits  = 12'h888;
    wrBits    = 12'h666;
    d = 8'h40;
    for (int i = 0; i < 6; i++) begin
      expQ.push_back(d);
      d = (i % 2 == 0) ? d + 8'h03 : 8'h40;
    end
    size = 32'd2; times = 32'd1; seed = 8'h40; step = 8'h03; ap_start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge ap_clk);
      checkOutput("b2b_ready", 32'(ap_ready), 32'(readyBits[c]));
      checkOutput("b2b_done", 32'(ap_done), 32'(doneBits[c]));
      checkOutput("b2b_wr_en", 32'(fifo_wr_en), 32'(wrBits[c]));
      if (fifo_wr_en) checkWrite("b2b");
      @(posedge ap_clk);
      #1;
      if (c == 8) ap_start = 1'b0;
    end
    @(negedge ap_clk);
    checkOutput("b2b_idle_end", 32'(ap_idle), 32'd1);
    checkOutput("b2b_sb_empty", 32'(expQ.size()), 32'd0);
    checkOutput("b2b_wr_count", wr_count, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
